// File: rtl/bsg_sync_sync_filter.sv
// Multi-flop bus synchroniser with a word-level stability filter and per-bit edge pulses.
// Latency: sync_stages_p + stable_cycles_p + 2 oclk edges (sync_stages_p when the filter is off).
// No backpressure: outputs update every oclk cycle and there is no flow control.
module bsg_sync_sync_filter #(
    parameter int                 width_p         = 32,
    parameter int                 sync_stages_p   = 2,
    parameter int                 stable_cycles_p = 4,
    parameter logic [width_p-1:0] reset_val_p     = '0
) (
    input  logic               oclk_i,
    input  logic               oclk_reset_n_i,
    input  logic [width_p-1:0] iclk_data_i,
    output logic [width_p-1:0] oclk_data_o,
    output logic [width_p-1:0] oclk_rise_o,
    output logic [width_p-1:0] oclk_fall_o,
    output logic               oclk_changed_o,
    output logic               oclk_settled_o
);

    logic [width_p-1:0] sync_r [sync_stages_p];
    logic [width_p-1:0] s_q;
    logic [width_p-1:0] prev_r;

    // Plain flop chain: no logic between stages so metastability has full cycles to resolve.
    always_ff @(posedge oclk_i or negedge oclk_reset_n_i) begin
        if (!oclk_reset_n_i) begin
            for (int i = 0; i < sync_stages_p; i++) begin
                sync_r[i] <= reset_val_p;
            end
        end else begin
            sync_r[0] <= iclk_data_i;
            for (int i = 1; i < sync_stages_p; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign s_q = sync_r[sync_stages_p-1];

    generate
        if (stable_cycles_p > 0) begin : g_filter
            localparam int               cnt_w   = $clog2(stable_cycles_p + 1);
            localparam logic [cnt_w-1:0] cnt_max = cnt_w'(stable_cycles_p);

            logic [width_p-1:0] cand_r;
            logic [width_p-1:0] data_r;
            logic [cnt_w-1:0]   cnt_r;

            // Acceptance looks at the pre-edge count, so a candidate that has just
            // matured is still committed in the cycle it gets replaced.
            always_ff @(posedge oclk_i or negedge oclk_reset_n_i) begin
                if (!oclk_reset_n_i) begin
                    cand_r <= reset_val_p;
                    data_r <= reset_val_p;
                    cnt_r  <= cnt_max;
                end else begin
                    if (s_q != cand_r) begin
                        cand_r <= s_q;
                        cnt_r  <= '0;
                    end else if (cnt_r != cnt_max) begin
                        cnt_r <= cnt_r + cnt_w'(1);
                    end
                    if (cnt_r == cnt_max) begin
                        data_r <= cand_r;
                    end
                end
            end

            assign oclk_data_o    = data_r;
            assign oclk_settled_o = (cnt_r == cnt_max) && (cand_r == data_r);
        end else begin : g_bypass
            assign oclk_data_o    = s_q;
            assign oclk_settled_o = 1'b1;
        end
    endgenerate

    always_ff @(posedge oclk_i or negedge oclk_reset_n_i) begin
        if (!oclk_reset_n_i) begin
            prev_r <= reset_val_p;
        end else begin
            prev_r <= oclk_data_o;
        end
    end

    assign oclk_rise_o    = oclk_data_o & ~prev_r;
    assign oclk_fall_o    = ~oclk_data_o & prev_r;
    assign oclk_changed_o = |(oclk_rise_o | oclk_fall_o);

endmodule

// File: tb/tb_bsg_sync_sync_filter.sv
// Directed bench: default-parameter instance plus a 3-stage bypass (no filter) instance.
module tb_bsg_sync_sync_filter;

    logic        clk;
    logic        rst_n;
    logic [31:0] din;
    logic [31:0] dout, rise, fall;
    logic        changed, settled;

    logic [3:0]  b_din;
    logic [3:0]  b_dout, b_rise, b_fall;
    logic        b_changed, b_settled;

    int vectors    = 0;
    int miscompares = 0;

    logic        seen_chg;
    logic [31:0] data_or;
    logic        b_settled_all;

    bsg_sync_sync_filter dut (
        .oclk_i         (clk),
        .oclk_reset_n_i (rst_n),
        .iclk_data_i    (din),
        .oclk_data_o    (dout),
        .oclk_rise_o    (rise),
        .oclk_fall_o    (fall),
        .oclk_changed_o (changed),
        .oclk_settled_o (settled)
    );

    bsg_sync_sync_filter #(
        .width_p         (4),
        .sync_stages_p   (3),
        .stable_cycles_p (0)
    ) dut_byp (
        .oclk_i         (clk),
        .oclk_reset_n_i (rst_n),
        .iclk_data_i    (b_din),
        .oclk_data_o    (b_dout),
        .oclk_rise_o    (b_rise),
        .oclk_fall_o    (b_fall),
        .oclk_changed_o (b_changed),
        .oclk_settled_o (b_settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        din   = 32'hFFFF_FFFF;
        b_din = 4'h0;

        // Reset defaults with a non-reset input applied
        step(3);
        check("rst_data",    dout, 32'h0);
        check("rst_rise",    rise, 32'h0);
        check("rst_fall",    fall, 32'h0);
        check("rst_changed", {31'b0, changed}, 32'h0);
        check("rst_settled", {31'b0, settled}, 32'h1);

        rst_n = 1'b1;
        step(7);
        check("rel_data_e7", dout, 32'h0);
        step(1);
        check("rel_data_e8", dout, 32'hFFFF_FFFF);
        check("rel_rise_e8", rise, 32'hFFFF_FFFF);
        check("rel_chg_e8",  {31'b0, changed}, 32'h1);
        step(1);
        check("rel_rise_e9", rise, 32'h0);
        check("rel_set_e9",  {31'b0, settled}, 32'h1);

        // Asynchronous reset while data is all-ones: immediate clear, no fall pulse
        step(3);
        #2;
        rst_n = 1'b0;
        din   = 32'h0;
        #1;
        check("arst_data",    dout, 32'h0);
        check("arst_fall",    fall, 32'h0);
        check("arst_changed", {31'b0, changed}, 32'h0);
        step(2);
        rst_n = 1'b1;
        step(10);

        // Latency and settled profile
        din = 32'h0000_A5A5;
        step(2);
        check("lat_set_e2",  {31'b0, settled}, 32'h1);
        step(1);
        check("lat_set_e3",  {31'b0, settled}, 32'h0);
        step(4);
        check("lat_data_e7", dout, 32'h0);
        check("lat_set_e7",  {31'b0, settled}, 32'h0);
        step(1);
        check("lat_data_e8", dout, 32'h0000_A5A5);
        check("lat_rise_e8", rise, 32'h0000_A5A5);
        check("lat_fall_e8", fall, 32'h0);
        check("lat_set_e8",  {31'b0, settled}, 32'h1);
        step(1);
        check("lat_rise_e9", rise, 32'h0);

        din = 32'h0;
        step(12);
        check("back_to_0", dout, 32'h0);

        // 4-cycle excursion is rejected
        seen_chg = 1'b0;
        data_or  = 32'h0;
        din = 32'h0000_00FF;
        for (int i = 0; i < 16; i++) begin
            if (i == 4) din = 32'h0;
            step(1);
            seen_chg = seen_chg | changed;
            data_or  = data_or | dout;
        end
        check("glitch4_chg",  {31'b0, seen_chg}, 32'h0);
        check("glitch4_data", data_or, 32'h0);

        // 5-cycle excursion is accepted, then released
        din = 32'h0000_00FF;
        step(5);
        din = 32'h0;
        step(2);
        check("g5_data_e7", dout, 32'h0);
        step(1);
        check("g5_data_e8", dout, 32'h0000_00FF);
        check("g5_rise_e8", rise, 32'h0000_00FF);
        step(1);
        check("g5_rise_e9", rise, 32'h0);
        step(3);
        check("g5_data_e12", dout, 32'h0000_00FF);
        step(1);
        check("g5_data_e13", dout, 32'h0);
        check("g5_fall_e13", fall, 32'h0000_00FF);
        step(1);
        check("g5_fall_e14", fall, 32'h0);
        step(4);

        // Mid-filter reset discards the pending candidate
        din = 32'h0000_003C;
        step(5);
        check("mid_set_pre", {31'b0, settled}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_data",    dout, 32'h0);
        check("mid_fall",    fall, 32'h0);
        check("mid_settled", {31'b0, settled}, 32'h1);
        step(2);
        rst_n = 1'b1;
        step(7);
        check("mid_data_e7", dout, 32'h0);
        step(1);
        check("mid_data_e8", dout, 32'h0000_003C);
        check("mid_rise_e8", rise, 32'h0000_003C);
        step(2);

        // Rise and fall in the same cycle
        din = 32'h0000_000F;
        step(10);
        check("mix_pre", dout, 32'h0000_000F);
        din = 32'h0000_00F0;
        step(7);
        check("mix_data_e7", dout, 32'h0000_000F);
        step(1);
        check("mix_data_e8", dout, 32'h0000_00F0);
        check("mix_rise_e8", rise, 32'h0000_00F0);
        check("mix_fall_e8", fall, 32'h0000_000F);
        check("mix_chg_e8",  {31'b0, changed}, 32'h1);
        step(1);
        check("mix_chg_e9",  {31'b0, changed}, 32'h0);
        check("mix_rise_e9", rise, 32'h0);
        check("mix_fall_e9", fall, 32'h0);

        // Bypass instance: 3 edges of latency, settled tied high
        b_settled_all = 1'b1;
        b_din = 4'h1;
        step(2);
        b_settled_all = b_settled_all & b_settled;
        check("byp_data_e2", {28'b0, b_dout}, 32'h0);
        step(1);
        b_settled_all = b_settled_all & b_settled;
        check("byp_data_e3", {28'b0, b_dout}, 32'h1);
        check("byp_rise_e3", {28'b0, b_rise}, 32'h1);
        check("byp_chg_e3",  {31'b0, b_changed}, 32'h1);
        step(1);
        b_settled_all = b_settled_all & b_settled;
        check("byp_rise_e4", {28'b0, b_rise}, 32'h0);
        check("byp_settled", {31'b0, b_settled_all}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bsg_sync_sync_filter.md
Name: bsg_sync_sync_filter

Overview:
- Parametrised successor to the fixed two-flop, 8-bit-sliced bus synchroniser in bsg_async.
- Configurable synchroniser depth and width, asynchronous active-low reset to a parametrised value, and a word-level stability (glitch) filter.
- Adds per-bit rise/fall pulse outputs for the destination domain.
- Sits at the oclk side of a clock crossing, for quasi-static buses such as Gray counters, config words and status flags.

Parameters:
- width_p, 32, data width in bits (>=1).
- sync_stages_p, 2, synchroniser flop depth (>=2).
- stable_cycles_p, 4, extra cycles the synchronised word must be held before it is accepted. 0 disables the filter.
- reset_val_p, '0, width_p-bit value loaded into every data-holding flop on reset.

Ports:
- oclk_i  in  1  destination clock. All flops are posedge.
- oclk_reset_n_i  in  1  asynchronous active-low reset. Deassertion is synchronous to oclk_i externally.
- iclk_data_i  in  width_p  source-domain bus, asynchronous to oclk_i.
- oclk_data_o  out  width_p  filtered, synchronised bus.
- oclk_rise_o  out  width_p  per-bit one-cycle pulse when the oclk_data_o bit goes 0->1.
- oclk_fall_o  out  width_p  per-bit one-cycle pulse when the oclk_data_o bit goes 1->0.
- oclk_changed_o  out  1  OR-reduction of (oclk_rise_o | oclk_fall_o).
- oclk_settled_o  out  1  high when no candidate value is pending acceptance.

Behaviour:
- Sync chain: sync_stages_p width_p-bit flops, with no logic between stages. The last stage is s_q. All stages reset asynchronously to reset_val_p.
- Filter state (stable_cycles_p>0):
  - cand_r, width_p bits.
  - cnt_r, $clog2(stable_cycles_p+1) bits.
  - data_r, which drives oclk_data_o.
- Each edge, in priority order:
  - If s_q != cand_r: cand_r<=s_q and cnt_r<=0.
  - Else if cnt_r != stable_cycles_p: cnt_r<=cnt_r+1. cnt_r saturates and never wraps.
  - Independently, if cnt_r==stable_cycles_p: data_r<=cand_r. This uses the pre-edge values, so it applies even in a cycle where cand_r is being replaced.
- Acceptance rule:
  - A value is accepted iff s_q holds it for >= stable_cycles_p+1 consecutive cycles.
  - Shorter excursions never reach oclk_data_o, and no pulses are produced for them.
- Latency, input change to oclk_data_o, stable input: sync_stages_p + stable_cycles_p + 2 oclk edges.
- stable_cycles_p==0: filter removed, oclk_data_o = s_q, latency sync_stages_p edges, oclk_settled_o tied 1.
- Edge detect:
  - prev_r <= oclk_data_o every edge.
  - oclk_rise_o = oclk_data_o & ~prev_r; oclk_fall_o = ~oclk_data_o & prev_r.
  - Pulses coincide with the first cycle oclk_data_o shows the new value and last exactly one cycle.
  - Multiple bits may pulse in the same cycle. Rise and fall are never both set on one bit.
- oclk_settled_o = (cnt_r==stable_cycles_p) && (cand_r==data_r).
- Reset (asynchronous, any time, including mid-filter):
  - Sync stages, cand_r, data_r and prev_r go to reset_val_p; cnt_r goes to stable_cycles_p.
  - Immediately after: oclk_data_o=reset_val_p, all pulses 0, oclk_changed_o=0, oclk_settled_o=1.
  - No pulse on reset assertion or release.
- A pending candidate is discarded by reset.
- An input that differs from reset_val_p at release propagates through the normal latency.

Test Plan:
- Reset/defaults: hold oclk_reset_n_i=0, iclk_data_i=0xFFFFFFFF -> oclk_data_o=0, rise/fall=0, settled=1. Release, keep input -> oclk_data_o=0xFFFFFFFF on edge 8, oclk_rise_o=0xFFFFFFFF for exactly that cycle.
- Latency: defaults, step input 0->0x0000A5A5 just before edge 1 -> oclk_data_o changes on edge 8 (2+4+2), rise=0x0000A5A5 for one cycle, settled low from edge 3 to edge 7, high again after edge 8.
- Glitch rejection: input 0->0xFF held 4 cycles then 0 -> oclk_data_o stays 0, no pulses, changed_o never 1. Held 5 cycles -> 0xFF accepted, rise=0xFF once, later fall=0xFF once when 0 is accepted.
- Bypass: stable_cycles_p=0, sync_stages_p=3, step 0->0x1 -> oclk_data_o=0x1 on edge 3, rise_o[0] one cycle, settled always 1.
- Mid-filter reset: defaults, step to 0x3C, assert reset at edge 5 -> outputs return to 0 asynchronously with no fall pulse. Release with input still 0x3C -> accepted 8 edges after release.
- Mixed edges: data_o=0x0F, input 0xF0 stable -> single cycle with rise=0xF0 and fall=0x0F together, changed_o=1.
